// File: rtl/reward_critic.sv
// Trial-based reward source: counts post-synaptic spikes over a fixed window and
// drives a held reward level when the count lands inside the target band.
module reward_critic #(
  parameter int WINDOW_LEN  = 16,
  parameter int TARGET_MIN  = 2,
  parameter int TARGET_MAX  = 4,
  parameter int REWARD_HOLD = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             trial_start,
  input  logic             post_spike,
  output logic             reward,
  output logic             trial_done,
  output logic             hit,
  output logic [CNT_W-1:0] spike_count,
  output logic [3:0]       hit_streak,
  output logic             busy
);

  localparam int WIN_W  = $clog2(WINDOW_LEN + 1);
  localparam int HOLD_W = $clog2(REWARD_HOLD + 1);

  typedef enum logic [1:0] {IDLE, WINDOW, EVAL, REWARD} state_t;

  state_t             state;
  state_t             next_state;
  logic [WIN_W-1:0]   win_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [CNT_W-1:0]   run_cnt;
  logic               win_last;
  logic               hold_last;
  logic               in_band;

  assign win_last  = (win_cnt == WIN_W'(WINDOW_LEN - 1));
  assign hold_last = (hold_cnt == HOLD_W'(REWARD_HOLD - 1));
  assign in_band   = (32'(run_cnt) >= 32'(TARGET_MIN)) && (32'(run_cnt) <= 32'(TARGET_MAX));
  assign busy      = (state != IDLE);

  always_comb begin
    next_state = state;
    trial_done = 1'b0;
    case (state)
      IDLE: begin
        if (trial_start && enable) next_state = WINDOW;
      end
      WINDOW: begin
        if (!enable)       next_state = IDLE;
        else if (win_last) next_state = EVAL;
      end
      EVAL: begin
        if (!enable) begin
          next_state = IDLE;
        end else begin
          trial_done = 1'b1;
          next_state = in_band ? REWARD : IDLE;
        end
      end
      REWARD: begin
        if (!enable || hold_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Counters are cleared while idle so a spike on the accepting cycle is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      reward      <= 1'b0;
      hit         <= 1'b0;
      spike_count <= '0;
      hit_streak  <= 4'd0;
      win_cnt     <= '0;
      hold_cnt    <= '0;
      run_cnt     <= '0;
    end else begin
      state  <= next_state;
      reward <= (next_state == REWARD);
      case (state)
        IDLE: begin
          win_cnt  <= '0;
          run_cnt  <= '0;
          hold_cnt <= '0;
        end
        WINDOW: begin
          win_cnt <= win_cnt + 1'b1;
          if (post_spike && (run_cnt != {CNT_W{1'b1}})) run_cnt <= run_cnt + 1'b1;
        end
        EVAL: begin
          hold_cnt <= '0;
          if (enable) begin
            spike_count <= run_cnt;
            hit         <= in_band;
            if (!in_band)                 hit_streak <= 4'd0;
            else if (hit_streak != 4'd15) hit_streak <= hit_streak + 4'd1;
          end
        end
        REWARD: begin
          hold_cnt <= hold_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reward_critic.sv
// Directed bench for reward_critic: hit/miss trials, band edges, saturation, abort and reset.
module tb_reward_critic;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       trialStart;
  logic       postSpike;
  logic       reward;
  logic       trialDone;
  logic       hit;
  logic [7:0] spikeCount;
  logic [3:0] hitStreak;
  logic       busy;
  logic       satReward;
  logic       satTrialDone;
  logic       satHit;
  logic [2:0] satSpikeCount;
  logic [3:0] satHitStreak;
  logic       satBusy;

  int checkCount = 0;
  int passCount  = 0;
  int expStreak  = 0;

  reward_critic dut (
    .clk(clk), .rst(rst), .enable(enable), .trial_start(trialStart),
    .post_spike(postSpike), .reward(reward), .trial_done(trialDone), .hit(hit),
    .spike_count(spikeCount), .hit_streak(hitStreak), .busy(busy)
  );

  reward_critic #(.CNT_W(3)) dutSat (
    .clk(clk), .rst(rst), .enable(enable), .trial_start(trialStart),
    .post_spike(postSpike), .reward(satReward), .trial_done(satTrialDone), .hit(satHit),
    .spike_count(satSpikeCount), .hit_streak(satHitStreak), .busy(satBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [15:0] mask, input logic startSpike);
    trialStart = 1'b1;
    postSpike  = startSpike;
    tick();
    trialStart = 1'b0;
    for (int i = 0; i < 16; i++) begin
      postSpike = mask[i];
      tick();
    end
    postSpike = 1'b0;
  endtask

  task automatic runTrial(input string tag, input logic [15:0] mask, input logic startSpike,
                          input int expCount, input logic expHit);
    applyStimulus(mask, startSpike);
    checkOutput({tag, "_done"}, 32'(trialDone), 32'd1);
    tick();
    expStreak = expHit ? ((expStreak == 15) ? 15 : expStreak + 1) : 0;
    checkOutput({tag, "_count"}, 32'(spikeCount), 32'(expCount));
    checkOutput({tag, "_hit"}, 32'(hit), 32'(expHit));
    checkOutput({tag, "_streak"}, 32'(hitStreak), 32'(expStreak));
    for (int i = 0; i < 4; i++) begin
      checkOutput({tag, "_reward"}, 32'(reward), 32'(expHit));
      tick();
    end
    checkOutput({tag, "_rewardEnd"}, 32'(reward), 32'd0);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; trialStart = 1'b0; postSpike = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_reward", 32'(reward), 32'd0);
    checkOutput("rst_done", 32'(trialDone), 32'd0);
    checkOutput("rst_hit", 32'(hit), 32'd0);
    checkOutput("rst_count", 32'(spikeCount), 32'd0);
    checkOutput("rst_streak", 32'(hitStreak), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    runTrial("hit3", 16'h0124, 1'b0, 3, 1'b1);
    runTrial("missLow", 16'h0010, 1'b0, 1, 1'b0);
    runTrial("missHigh", 16'h1F00, 1'b0, 5, 1'b0);
    runTrial("edge2", 16'h0081, 1'b0, 2, 1'b1);
    runTrial("edge4", 16'h8007, 1'b1, 4, 1'b1);
    runTrial("lastCycle", 16'h8001, 1'b0, 2, 1'b1);
    runTrial("startSpike", 16'h8000, 1'b1, 1, 1'b0);

    runTrial("satMain", 16'hFFFF, 1'b0, 16, 1'b0);
    checkOutput("sat_count", 32'(satSpikeCount), 32'd7);
    checkOutput("sat_hit", 32'(satHit), 32'd0);

    for (int n = 0; n < 17; n++) runTrial("streak", 16'h0003, 1'b0, 2, 1'b1);
    checkOutput("streak_cap", 32'(hitStreak), 32'd15);
    runTrial("streakMiss", 16'h0000, 1'b0, 0, 1'b0);
    checkOutput("streak_clear", 32'(hitStreak), 32'd0);

    runTrial("preAbort", 16'h0003, 1'b0, 2, 1'b1);
    trialStart = 1'b1;
    tick();
    trialStart = 1'b0;
    for (int i = 1; i < 8; i++) begin
      postSpike = 1'b1;
      tick();
    end
    checkOutput("abort_busyBefore", 32'(busy), 32'd1);
    enable = 1'b0;
    postSpike = 1'b0;
    tick();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_count", 32'(spikeCount), 32'd2);
    checkOutput("abort_hit", 32'(hit), 32'd1);
    checkOutput("abort_streak", 32'(hitStreak), 32'd1);
    for (int i = 0; i < 12; i++) begin
      checkOutput("abort_noDone", 32'(trialDone), 32'd0);
      tick();
    end
    enable = 1'b1;

    applyStimulus(16'h0003, 1'b0);
    tick();
    checkOutput("enReward_on", 32'(reward), 32'd1);
    checkOutput("enReward_streak", 32'(hitStreak), 32'd2);
    tick();
    enable = 1'b0;
    tick();
    checkOutput("enReward_off", 32'(reward), 32'd0);
    checkOutput("enReward_idle", 32'(busy), 32'd0);
    checkOutput("enReward_kept", 32'(hitStreak), 32'd2);
    enable = 1'b1;
    tick();

    applyStimulus(16'h0007, 1'b0);
    tick();
    checkOutput("rstReward_on", 32'(reward), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstReward_reward", 32'(reward), 32'd0);
    checkOutput("rstReward_busy", 32'(busy), 32'd0);
    checkOutput("rstReward_hit", 32'(hit), 32'd0);
    checkOutput("rstReward_count", 32'(spikeCount), 32'd0);
    checkOutput("rstReward_streak", 32'(hitStreak), 32'd0);
    expStreak = 0;
    runTrial("postReset", 16'h0300, 1'b0, 2, 1'b1);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
